// File: rtl/cache_pkg.sv
// Shared sizing, FSM state type and address-field helpers for the direct-mapped data cache.
package cache_pkg;
  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int IDX_W       = $clog2(NUM_BLOCKS);
  localparam int OFF_W       = $clog2(BLOCK_BYTES);
  localparam int TAG_W       = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W      = DATA_W * BLOCK_BYTES;
  localparam int MADDR_W     = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBACK  = 2'd1,
    MEM_RD = 2'd2,
    UPDATE = 2'd3
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction
endpackage

// File: rtl/cache_store.sv
// Line, tag, valid and dirty arrays: one synchronous write port (refill or byte store),
// one combinational read port at the requested index.
module cache_store
  import cache_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [OFF_W-1:0]  i_off,
  input  logic              i_fill_en,
  input  logic [TAG_W-1:0]  i_fill_tag,
  input  logic [LINE_W-1:0] i_fill_data,
  input  logic              i_byte_en,
  input  logic [DATA_W-1:0] i_byte_data,
  output logic [LINE_W-1:0] o_line,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  output logic              o_dirty
);
  logic [LINE_W-1:0]     r_line [NUM_BLOCKS];
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;

  // Lines are cleared too so READDATA reads 0 out of reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
      r_dirty <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        r_line[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (i_fill_en) begin
      r_line[i_idx]  <= i_fill_data;
      r_tag[i_idx]   <= i_fill_tag;
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_byte_en) begin
      r_line[i_idx][{i_off, 3'b000} +: DATA_W] <= i_byte_data;
      r_dirty[i_idx] <= 1'b1;
    end
  end

  assign o_line  = r_line[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller: hit logic plus the
// refill/write-back FSM in front of a block-wide, multi-cycle data memory.
//
//  state  | meaning
//  IDLE   | serve hits; on a miss pick WBACK (dirty victim) or MEM_RD
//  WBACK  | victim line written to memory until MEM_BUSYWAIT drops
//  MEM_RD | requested block read from memory until MEM_BUSYWAIT drops
//  UPDATE | refill written into the line, then back to IDLE to hit
module data_cache_ctrl
  import cache_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_read,
  input  logic               i_write,
  input  logic [ADDR_W-1:0]  i_address,
  input  logic [DATA_W-1:0]  i_writedata,
  output logic [DATA_W-1:0]  o_readdata,
  output logic               o_busywait,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic [MADDR_W-1:0] o_mem_address,
  output logic [LINE_W-1:0]  o_mem_writedata,
  input  logic [LINE_W-1:0]  i_mem_readdata,
  input  logic               i_mem_busywait
);
  state_t             r_state;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [MADDR_W-1:0] r_mem_address;
  logic [LINE_W-1:0]  r_mem_writedata;

  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_idx;
  logic [OFF_W-1:0]   w_off;
  logic [LINE_W-1:0]  w_line;
  logic [TAG_W-1:0]   w_line_tag;
  logic               w_valid;
  logic               w_dirty;
  logic               w_wr;
  logic               w_req;
  logic               w_hit;
  logic               w_miss;
  logic               w_byte_en;
  logic               w_fill_en;

  assign w_tag = addr_tag(i_address);
  assign w_idx = addr_idx(i_address);
  assign w_off = addr_off(i_address);

  // READ and WRITE together is treated as a READ.
  assign w_wr      = i_write & ~i_read;
  assign w_req     = i_read | w_wr;
  assign w_hit     = w_valid & (w_line_tag == w_tag);
  assign w_miss    = w_req & ~w_hit;
  assign w_byte_en = (r_state == IDLE) & w_wr & w_hit;
  assign w_fill_en = (r_state == UPDATE);

  cache_store u_store (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_idx       (w_idx),
    .i_off       (w_off),
    .i_fill_en   (w_fill_en),
    .i_fill_tag  (w_tag),
    .i_fill_data (i_mem_readdata),
    .i_byte_en   (w_byte_en),
    .i_byte_data (i_writedata),
    .o_line      (w_line),
    .o_tag       (w_line_tag),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            if (w_dirty) begin
              r_state         <= WBACK;
              r_mem_write     <= 1'b1;
              r_mem_address   <= {w_line_tag, w_idx};
              r_mem_writedata <= w_line;
            end else begin
              r_state       <= MEM_RD;
              r_mem_read    <= 1'b1;
              r_mem_address <= {w_tag, w_idx};
            end
          end
        end
        WBACK: begin
          if (!i_mem_busywait) begin
            r_state         <= MEM_RD;
            r_mem_write     <= 1'b0;
            r_mem_writedata <= '0;
            r_mem_read      <= 1'b1;
            r_mem_address   <= {w_tag, w_idx};
          end
        end
        MEM_RD: begin
          if (!i_mem_busywait) begin
            r_state       <= UPDATE;
            r_mem_read    <= 1'b0;
            r_mem_address <= '0;
          end
        end
        UPDATE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_readdata      = w_line[{w_off, 3'b000} +: DATA_W];
  assign o_busywait      = (r_state != IDLE) | w_miss;
  assign o_mem_read      = r_mem_read;
  assign o_mem_write     = r_mem_write;
  assign o_mem_address   = r_mem_address;
  assign o_mem_writedata = r_mem_writedata;
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: directed scenarios then randomized accesses, checked every
// cycle against a transaction-level cache/memory model.
module tb_data_cache_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        busy;
  logic        mrd;
  logic        mwr;
  logic [5:0]  maddr;
  logic [31:0] mwdata;
  logic [31:0] mrdata = 32'h0;
  logic        mbusy = 1'b0;

  data_cache_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_read(rd), .i_write(wr),
    .i_address(addr), .i_writedata(wdata), .o_readdata(rdata), .o_busywait(busy),
    .o_mem_read(mrd), .o_mem_write(mwr), .o_mem_address(maddr),
    .o_mem_writedata(mwdata), .i_mem_readdata(mrdata), .i_mem_busywait(mbusy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Physical memory (written by the DUT) and the model's own view of memory.
  logic [31:0] phys_mem [64];
  logic [31:0] m_mem [64];
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [2:0]  m_tag [8];
  logic [31:0] m_line [8];

  int lat_wb = 0;
  int lat_rd = 0;

  bit          e_en = 1'b0;
  bit          e_busy, e_mrd, e_mwr, e_chk;
  logic [5:0]  e_maddr;
  logic [31:0] e_mwdata;
  logic [7:0]  e_rdata;

  logic [7:0]  last_rdata;
  logic [5:0]  last_wb_addr, last_rd_addr;
  logic [31:0] last_wb_data;
  int          busy_run = 0;
  int          last_busy_run = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: holds MEM_BUSYWAIT for the programmed latency of each request.
  initial begin
    int cnt = 0;
    logic [1:0] last_op = 2'b00;
    logic [1:0] op;
    forever begin
      @(posedge clk);
      #1;
      op = {mrd, mwr};
      if (op == 2'b00) begin
        cnt = 0;
        mbusy = 1'b0;
      end else begin
        if (op != last_op) cnt = 0;
        if (cnt < (mrd ? lat_rd : lat_wb)) begin
          mbusy = 1'b1;
          cnt++;
        end else begin
          mbusy = 1'b0;
          if (mrd) mrdata = phys_mem[maddr];
          else phys_mem[maddr] = mwdata;
        end
      end
      last_op = op;
    end
  end

  // Compare process: checks DUT outputs against the current expectation every cycle.
  always @(negedge clk) begin
    if (e_en) begin
      check("busywait", 32'(busy), 32'(e_busy));
      check("mem_read", 32'(mrd), 32'(e_mrd));
      check("mem_write", 32'(mwr), 32'(e_mwr));
      check("mem_address", 32'(maddr), 32'(e_maddr));
      check("mem_writedata", mwdata, e_mwdata);
      if (e_chk) check("readdata", 32'(rdata), 32'(e_rdata));
    end
    if (e_chk) last_rdata = rdata;
    if (mwr) begin
      last_wb_addr = maddr;
      last_wb_data = mwdata;
    end
    if (mrd) last_rd_addr = maddr;
    if (busy) busy_run++;
    else begin
      if (busy_run != 0) last_busy_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic cyc(input bit b, input bit r, input bit w, input logic [5:0] ma,
                     input logic [31:0] md, input bit c, input logic [7:0] rv);
    e_busy = b; e_mrd = r; e_mwr = w; e_maddr = ma; e_mwdata = md;
    e_chk = c; e_rdata = rv; e_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // One CPU access from request to its hit cycle; inputs drop afterwards.
  task automatic do_access(input bit r, input bit w, input logic [7:0] a,
                           input logic [7:0] d, input int lwb, input int lrd);
    int idx, off;
    logic [2:0] tg;
    logic [31:0] ln;
    idx = int'(a[4:2]); off = int'(a[1:0]); tg = a[7:5];
    lat_wb = lwb; lat_rd = lrd;
    rd = r; wr = w; addr = a; wdata = d;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      cyc(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 8'h00);
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int i = 0; i <= lwb; i++)
          cyc(1'b1, 1'b0, 1'b1, {m_tag[idx], a[4:2]}, m_line[idx], 1'b0, 8'h00);
        m_mem[{m_tag[idx], a[4:2]}] = m_line[idx];
      end
      for (int i = 0; i <= lrd; i++)
        cyc(1'b1, 1'b1, 1'b0, a[7:2], 32'h0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 8'h00);
      m_line[idx] = m_mem[a[7:2]];
      m_tag[idx] = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    ln = m_line[idx];
    if (r) begin
      cyc(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b1, ln[off*8 +: 8]);
    end else begin
      cyc(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 8'h00);
      ln[off*8 +: 8] = d;
      m_line[idx] = ln;
      m_dirty[idx] = 1'b1;
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    logic [2:0] rtg, rix;
    logic [1:0] rof;
    int kind;
    for (int i = 0; i < 64; i++) begin
      phys_mem[i] = $urandom;
      m_mem[i] = phys_mem[i];
    end
    phys_mem[0] = 32'h44332211;
    m_mem[0] = 32'h44332211;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b1, 8'h00);

    // Cold read miss, then a same-line hit in the very next cycle.
    do_access(1'b1, 1'b0, 8'h00, 8'h00, 0, 2);
    check("t1_mem_address", 32'(last_rd_addr), 32'h00);
    check("t1_readdata", 32'(last_rdata), 32'h11);
    do_access(1'b1, 1'b0, 8'h01, 8'h00, 0, 0);
    check("t2_readdata", 32'(last_rdata), 32'h22);

    // Store hit then load back the same byte.
    do_access(1'b0, 1'b1, 8'h02, 8'hAB, 0, 0);
    do_access(1'b1, 1'b0, 8'h02, 8'h00, 0, 0);
    check("t3_readdata", 32'(last_rdata), 32'hAB);

    // Conflict miss on a dirty line: write-back then refill.
    do_access(1'b1, 1'b0, 8'h20, 8'h00, 1, 1);
    check("t4_wb_address", 32'(last_wb_addr), 32'h00);
    check("t4_wb_data", last_wb_data, 32'h44AB2211);
    check("t4_rd_address", 32'(last_rd_addr), 32'h08);

    // Reset in the middle of a refill.
    lat_rd = 10;
    rd = 1'b1; addr = 8'h40;
    cyc(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 6'h10, 32'h0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 6'h10, 32'h0, 1'b0, 8'h00);
    reset = 1'b1; rd = 1'b0; addr = 8'h00;
    cyc(1'b1, 1'b1, 1'b0, 6'h10, 32'h0, 1'b0, 8'h00);
    reset = 1'b0;
    model_reset();
    cyc(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b1, 8'h00);
    do_access(1'b1, 1'b0, 8'h00, 8'h00, 0, 0);
    check("t5_refetch", 32'(last_rdata), 32'h11);

    // Long memory stall on a clean miss.
    do_access(1'b1, 1'b0, 8'h04, 8'h00, 0, 5);
    idle(1);
    check("t6_busy_cycles", 32'(last_busy_run), 32'd8);

    // Randomized traffic over four indices to force hits, conflicts and write-backs.
    for (int t = 0; t < 300; t++) begin
      rtg = 3'($urandom_range(0, 7));
      rix = 3'($urandom_range(0, 3));
      rof = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 15);
      do_access(kind < 8, kind >= 7, {rtg, rix, rof}, 8'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);
    e_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
